sm83_cycle_sequencer: RTL

Parametrised T-state / M-cycle sequencer for the SM83 core, the successor to the fixed 4T/6M sequencer. It generates one-hot and binary T-state and M-cycle phases, and adds wait-state stalls, M-cycle jump loads for skipped operand fetches, and a sticky protocol-error flag. Instruction decode and the bus interface consume its phase outputs.

---
 rtl/sm83_cycle_sequencer_if.sv | 38 +++
 rtl/sm83_cycle_sequencer.sv | 91 +++++++++
 2 files changed

// File: rtl/sm83_cycle_sequencer_if.sv
// ============================================================================
// sm83_cycle_sequencer_if : control and phase bundle of the T/M sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sm83_cycle_sequencer_if #(
  parameter int NUM_T = 4,
  parameter int NUM_M = 6
);
  localparam int TW = $clog2(NUM_T);
  localparam int MW = $clog2(NUM_M);

  logic             ncyc;
  logic             stall;
  logic             set_m1;
  logic             load_m;
  logic [MW-1:0]    load_idx;
  logic             err_clr;
  logic [NUM_T-1:0] t;
  logic [NUM_M-1:0] m;
  logic [TW-1:0]    t_idx;
  logic [MW-1:0]    m_idx;
  logic             cyc_end;
  logic             err;

  modport master (
    output ncyc, stall, set_m1, load_m, load_idx, err_clr,
    input  t, m, t_idx, m_idx, cyc_end, err
  );

  modport slave (
    input  ncyc, stall, set_m1, load_m, load_idx, err_clr,
    output t, m, t_idx, m_idx, cyc_end, err
  );
endinterface

`default_nettype wire

// File: rtl/sm83_cycle_sequencer.sv
// ============================================================================
// sm83_cycle_sequencer : T-state / M-cycle phase generator with stalls, jumps
// Revision: 1.0
// ============================================================================
`default_nettype none

module sm83_cycle_sequencer #(
  parameter int NUM_T = 4,
  parameter int NUM_M = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  sm83_cycle_sequencer_if.slave  bus
);
  localparam int TW = $clog2(NUM_T);
  localparam int MW = $clog2(NUM_M);
  localparam logic [TW-1:0] T_LAST  = TW'(NUM_T - 1);
  localparam logic [MW-1:0] M_LAST  = MW'(NUM_M - 1);
  localparam logic [MW:0]   M_LIMIT = (MW+1)'(NUM_M);

  logic [NUM_T-1:0] t_q, t_d;
  logic [NUM_M-1:0] m_q, m_d;
  logic [TW-1:0]    t_idx_q, t_idx_d;
  logic [MW-1:0]    m_idx_q, m_idx_d;
  logic             err_q, err_d;
  logic             err_set;
  logic             cyc_end;

  assign cyc_end = t_q[NUM_T-1] && !bus.stall && !bus.ncyc;

  always_comb begin
    t_idx_d = t_idx_q;
    m_idx_d = m_idx_q;
    err_set = 1'b0;

    if (bus.ncyc) begin
      t_idx_d = '0;
    end else if (!bus.stall) begin
      t_idx_d = (t_idx_q == T_LAST) ? '0 : t_idx_q + 1'b1;
    end

    // M moves only on the edge that closes a cycle; requests elsewhere are protocol errors
    if (cyc_end) begin
      if (bus.set_m1) begin
        m_idx_d = '0;
      end else if (bus.load_m) begin
        if ({1'b0, bus.load_idx} >= M_LIMIT) begin
          m_idx_d = '0;
          err_set = 1'b1;
        end else begin
          m_idx_d = bus.load_idx;
        end
      end else if (m_idx_q == M_LAST) begin
        err_set = 1'b1;
      end else begin
        m_idx_d = m_idx_q + 1'b1;
      end
    end else if (bus.set_m1 || bus.load_m) begin
      err_set = 1'b1;
    end

    err_d = err_set | (err_q & ~bus.err_clr);
    t_d   = {{(NUM_T-1){1'b0}}, 1'b1} << t_idx_d;
    m_d   = {{(NUM_M-1){1'b0}}, 1'b1} << m_idx_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t_q     <= {{(NUM_T-1){1'b0}}, 1'b1};
      m_q     <= {{(NUM_M-1){1'b0}}, 1'b1};
      t_idx_q <= '0;
      m_idx_q <= '0;
      err_q   <= 1'b0;
    end else begin
      t_q     <= t_d;
      m_q     <= m_d;
      t_idx_q <= t_idx_d;
      m_idx_q <= m_idx_d;
      err_q   <= err_d;
    end
  end

  assign bus.t       = t_q;
  assign bus.m       = m_q;
  assign bus.t_idx   = t_idx_q;
  assign bus.m_idx   = m_idx_q;
  assign bus.cyc_end = cyc_end;
  assign bus.err     = err_q;
endmodule

`default_nettype wire
